// File: rtl/dbg_apb_master.sv
// Purpose: APB3 initiator that turns single-beat debug read/write commands into SETUP/ACCESS transfers.
// Latency: psel one cycle after acceptance, penable one cycle later, rsp_valid one cycle after pready (plus wait states).
// Backpressure: one transaction in flight; cmd_ready drops until the response is taken, and rsp_* stays held while rsp_ready=0.
module dbg_apb_master #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    // A zero-width counter is illegal, so keep one bit when the timeout is disabled.
    localparam int CNT_W = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                state_q, state_n;
    logic [CNT_W-1:0]      cnt_q, cnt_n;
    logic                  cmd_ready_n;
    logic                  rsp_valid_n;
    logic [DATA_WIDTH-1:0] rsp_rdata_n;
    logic                  rsp_err_n;
    logic                  rsp_timeout_n;
    logic                  psel_n;
    logic                  penable_n;
    logic                  pwrite_n;
    logic [ADDR_WIDTH-1:0] paddr_n;
    logic [DATA_WIDTH-1:0] pwdata_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            cmd_ready   <= cmd_ready_n;
            rsp_valid   <= rsp_valid_n;
            rsp_rdata   <= rsp_rdata_n;
            rsp_err     <= rsp_err_n;
            rsp_timeout <= rsp_timeout_n;
            psel        <= psel_n;
            penable     <= penable_n;
            pwrite      <= pwrite_n;
            paddr       <= paddr_n;
            pwdata      <= pwdata_n;
        end
    end

    always_comb begin
        state_n       = state_q;
        cnt_n         = cnt_q;
        cmd_ready_n   = cmd_ready;
        rsp_valid_n   = rsp_valid;
        rsp_rdata_n   = rsp_rdata;
        rsp_err_n     = rsp_err;
        rsp_timeout_n = rsp_timeout;
        psel_n        = psel;
        penable_n     = penable;
        pwrite_n      = pwrite;
        paddr_n       = paddr;
        pwdata_n      = pwdata;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cmd_ready_n = 1'b0;
                    if (cmd_addr[1:0] == 2'b00) begin
                        pwrite_n  = cmd_write;
                        paddr_n   = cmd_addr;
                        pwdata_n  = cmd_wdata;
                        psel_n    = 1'b1;
                        penable_n = 1'b0;
                        state_n   = SETUP;
                    end else begin
                        // Misaligned: answer with an error without touching the bus.
                        rsp_valid_n   = 1'b1;
                        rsp_err_n     = 1'b1;
                        rsp_timeout_n = 1'b0;
                        rsp_rdata_n   = '0;
                        state_n       = RESP;
                    end
                end
            end
            SETUP: begin
                penable_n = 1'b1;
                cnt_n     = '0;
                state_n   = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    rsp_rdata_n   = (pwrite || pslverr) ? '0 : prdata;
                    rsp_err_n     = pslverr;
                    rsp_timeout_n = 1'b0;
                    rsp_valid_n   = 1'b1;
                    psel_n        = 1'b0;
                    penable_n     = 1'b0;
                    state_n       = RESP;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    rsp_rdata_n   = '0;
                    rsp_err_n     = 1'b1;
                    rsp_timeout_n = 1'b1;
                    rsp_valid_n   = 1'b1;
                    psel_n        = 1'b0;
                    penable_n     = 1'b0;
                    state_n       = RESP;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    cmd_ready_n = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dbg_apb_master.sv
// Directed plus randomized bench for dbg_apb_master; the bench plays the APB responder
// and predicts every response from the transaction parameters alone.
module tb_dbg_apb_master;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dbg_apb_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command, play the responder (pready after 'waits' wait states),
    // hold off the response for 'hold' cycles, and check everything against the model.
    task automatic do_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input int waits, input logic slverr, input logic [DW-1:0] rdata,
                          input int hold);
        logic          mis;
        int            exp_pen;
        logic [DW-1:0] exp_rdata;
        logic          exp_err, exp_to;
        int            cnt;
        int            guard;

        mis = (addr[1:0] != 2'b00);
        if (mis) begin
            exp_pen = 0; exp_err = 1'b1; exp_to = 1'b0; exp_rdata = '0;
        end else if (waits < TO) begin
            exp_pen = waits + 1; exp_err = slverr; exp_to = 1'b0;
            exp_rdata = (wr || slverr) ? '0 : rdata;
        end else begin
            exp_pen = TO; exp_err = 1'b1; exp_to = 1'b1; exp_rdata = '0;
        end

        guard = 0;
        while (!cmd_ready && guard < 50) begin
            step();
            guard++;
        end
        chk("cmd_ready_before_cmd", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        step();
        cmd_valid = 1'b0;
        cmd_write = $urandom; cmd_addr = AW'($urandom); cmd_wdata = $urandom;
        chk("cmd_ready_after_accept", cmd_ready, 1'b0);

        if (mis) begin
            chk("mis_psel", psel, 1'b0);
            chk("mis_rsp_valid", rsp_valid, 1'b1);
        end else begin
            chk("setup_psel_pen", {psel, penable}, 2'b10);
            chk("setup_bus", {pwrite, paddr, pwdata}, {wr, addr, wdata});
            step();
            cnt = 0;
            while (penable && cnt < 300) begin
                chk("access_psel", psel, 1'b1);
                chk("access_bus", {pwrite, paddr, pwdata}, {wr, addr, wdata});
                pready  = (cnt == waits);
                pslverr = (cnt == waits) ? slverr : 1'($urandom);
                prdata  = (cnt == waits) ? rdata : $urandom;
                step();
                cnt++;
            end
            pready = 1'b0; pslverr = 1'b0;
            chk("penable_cycles", cnt, exp_pen);
            chk("end_psel_pen", {psel, penable}, 2'b00);
        end

        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_fields", {rsp_err, rsp_timeout, rsp_rdata}, {exp_err, exp_to, exp_rdata});
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {1'b1, exp_err, exp_to, exp_rdata});
            chk("hold_ready_bus", {cmd_ready, psel, penable}, 3'b000);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("after_rsp", {rsp_valid, cmd_ready}, 2'b01);
        if (!mis)
            chk("bus_held_idle", {pwrite, paddr, pwdata}, {wr, addr, wdata});
    endtask

    initial begin
        logic [AW-1:0] offs[$];
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int w;
        for (int i = 0; i < 4; i++) offs.push_back(AW'(4 * i));
        for (int i = 0; i < 32; i++) offs.push_back(AW'(12'h010 + 4 * i));
        for (int i = 0; i < 4; i++) offs.push_back(AW'(12'h100 + 4 * i));

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("reset_cmd_ready", cmd_ready, 1'b1);
        chk("reset_outputs", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout, psel, penable, pwrite, paddr, pwdata}, '0);

        do_txn(1'b1, 12'h000, 32'h0000_0001, 0, 1'b0, 32'h1234_5678, 0);
        do_txn(1'b0, 12'h014, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, 0);
        do_txn(1'b0, 12'h104, 32'h0, 0, 1'b1, 32'hCAFE_F00D, 0);
        do_txn(1'b0, 12'h008, 32'h0, 1000, 1'b0, 32'h1111_2222, 0);
        do_txn(1'b0, 12'h00C, 32'h0, TO - 1, 1'b0, 32'h3333_4444, 0);
        do_txn(1'b1, 12'h010, 32'h5555_6666, TO - 2, 1'b1, 32'h0, 1);
        do_txn(1'b0, 12'h00E, 32'h0, 0, 1'b0, 32'h7777_8888, 0);
        do_txn(1'b0, 12'h018, 32'h0, 1, 1'b0, 32'hA5A5_5A5A, 5);

        // Reset mid-ACCESS of a read drops the transfer.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h008;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("pre_reset_access", {psel, penable}, 2'b11);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("post_reset", {psel, penable, rsp_valid, cmd_ready}, 4'b0001);
        step();
        chk("post_reset_quiet", {psel, rsp_valid}, 2'b00);
        do_txn(1'b0, 12'h100, 32'h0, 2, 1'b0, 32'h0BAD_CAFE, 0);

        for (int n = 0; n < 40; n++) begin
            a = offs[$urandom_range(0, offs.size() - 1)];
            if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
            d = $urandom;
            w = $urandom_range(0, 10);
            do_txn(1'($urandom), a, d, w, ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
